wb_stream_packer: RTL



---
 rtl/wb_streamer_pkg.sv | 11 +
 rtl/wb_stream_packer_if.sv | 30 +++
 rtl/wb_stream_packer.sv | 92 +++++++++
 3 files changed

// File: rtl/wb_streamer_pkg.sv
// Shared definitions for the stream-to-memory reader and its upstream packer.
package wb_streamer_pkg;
  localparam int WB_DW = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction
endpackage

// File: rtl/wb_stream_packer_if.sv
// Narrow sample stream in, packed word stream out, plus flush/busy sideband.
interface wb_stream_packer_if
  import wb_streamer_pkg::*;
#(
  parameter int IN_DW  = 8,
  parameter int OUT_DW = WB_DW
);
  localparam int RATIO = OUT_DW / IN_DW;

  logic [IN_DW-1:0]  stream_s_data_i;
  logic              stream_s_valid_i;
  logic              stream_s_ready_o;
  logic              stream_s_last_i;
  logic              flush_i;
  logic [OUT_DW-1:0] stream_m_data_o;
  logic              stream_m_valid_o;
  logic              stream_m_ready_i;
  logic [RATIO-1:0]  stream_m_keep_o;
  logic              busy_o;

  modport slave (
    input  stream_s_data_i, stream_s_valid_i, stream_s_last_i, flush_i, stream_m_ready_i,
    output stream_s_ready_o, stream_m_data_o, stream_m_valid_o, stream_m_keep_o, busy_o
  );

  modport master (
    output stream_s_data_i, stream_s_valid_i, stream_s_last_i, flush_i, stream_m_ready_i,
    input  stream_s_ready_o, stream_m_data_o, stream_m_valid_o, stream_m_keep_o, busy_o
  );
endinterface

// File: rtl/wb_stream_packer.sv
// Packs IN_DW samples little-endian into OUT_DW words with a lane-keep mask;
// partial words leave on last/flush through a single registered output stage.
module wb_stream_packer
  import wb_streamer_pkg::*;
#(
  parameter int IN_DW  = 8,
  parameter int OUT_DW = WB_DW
) (
  input logic              clk,
  input logic              rst,
  wb_stream_packer_if.slave bus
);
  localparam int RATIO = OUT_DW / IN_DW;
  localparam int IDX_W = clog2(RATIO);
  localparam int CNT_W = clog2(RATIO + 1);

  generate
    if ((OUT_DW % IN_DW) != 0 || RATIO < 2) begin : g_bad_cfg
      $error("wb_stream_packer: OUT_DW must be a multiple of IN_DW with at least 2 lanes");
    end
  endgenerate

  logic [OUT_DW-1:0] acc, acc_in, acc_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              flush_pend, flush_pend_n;
  logic [OUT_DW-1:0] m_data, m_data_n;
  logic [RATIO-1:0]  m_keep, m_keep_n, keep_in;
  logic              m_valid, m_valid_n;

  logic             slot_free, s_ready, accept, complete, emit;
  logic [CNT_W-1:0] lanes;

  assign slot_free = !m_valid || bus.stream_m_ready_i;
  assign s_ready   = !flush_pend && (idx != IDX_W'(RATIO - 1) || slot_free);
  assign accept    = bus.stream_s_valid_i && s_ready;
  assign complete  = accept && (idx == IDX_W'(RATIO - 1) || bus.stream_s_last_i);
  // flush_pend blocks accepts, so the two emit sources never coincide
  assign emit      = slot_free && (complete || flush_pend);
  assign lanes     = CNT_W'(idx) + CNT_W'(accept);

  always_comb begin
    acc_in = acc;
    if (accept) acc_in[int'(idx)*IN_DW +: IN_DW] = bus.stream_s_data_i;
    keep_in = '0;
    for (int l = 0; l < RATIO; l++) keep_in[l] = (CNT_W'(l) < lanes);
  end

  always_comb begin
    acc_n        = acc_in;
    idx_n        = idx + IDX_W'(accept);
    flush_pend_n = flush_pend;
    m_data_n     = m_data;
    m_keep_n     = m_keep;
    m_valid_n    = m_valid;
    if (emit) begin
      m_data_n     = acc_in;
      m_keep_n     = keep_in;
      m_valid_n    = 1'b1;
      acc_n        = '0;
      idx_n        = '0;
      flush_pend_n = 1'b0;
    end else begin
      if (m_valid && bus.stream_m_ready_i) m_valid_n = 1'b0;
      // a last sample against a stalled output parks the word as a pending flush
      if (complete || (bus.flush_i && lanes != '0)) flush_pend_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      idx        <= '0;
      flush_pend <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
      m_valid    <= 1'b0;
    end else begin
      acc        <= acc_n;
      idx        <= idx_n;
      flush_pend <= flush_pend_n;
      m_data     <= m_data_n;
      m_keep     <= m_keep_n;
      m_valid    <= m_valid_n;
    end
  end

  assign bus.stream_s_ready_o = s_ready;
  assign bus.stream_m_data_o  = m_data;
  assign bus.stream_m_keep_o  = m_keep;
  assign bus.stream_m_valid_o = m_valid;
  assign bus.busy_o           = (idx != '0) || flush_pend || m_valid;
endmodule
